ps2_keycode_rx: RTL

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and turns them into 16-bit key events. It feeds the keycode-to-notes decoder. Break (`F0`) prefixes are folded into a single event, `{8'hF0, code}` for key-up and `{8'h00, code}` for key-down, and each event is announced by a one-cycle `start` pulse. Line glitches, bad frames and stalled frames are filtered out so the decoder only ever sees complete, valid events.

---
 rtl/ps2_keycode_rx_pkg.sv | 14 +
 rtl/ps2_keycode_rx_if.sv | 9 +
 rtl/ps2_keycode_rx_clk_filter.sv | 56 +++++
 rtl/ps2_keycode_rx.sv | 132 +++++++++++++
 4 files changed

// File: rtl/ps2_keycode_rx_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Key-event bus from the PS/2 receiver to the keycode-to-notes decoder.
interface ps2_keycode_rx_if;
    logic [15:0] keycode;
    logic        start;
    logic        frame_err;

    modport master (output keycode, output start, output frame_err);
    modport slave  (input  keycode, input  start, input  frame_err);
endinterface

// File: rtl/ps2_keycode_rx_clk_filter.sv
// Synchronizes the raw PS/2 pins, de-glitches the clock line and produces a
// one-cycle pulse on each filtered falling edge plus the synchronized data.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] LOAD = CW'(FILTER_LEN - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          fclk;
    logic [CW-1:0] cnt;

    // Two-stage synchronizers; idle-high lines reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Down-counter: fclk follows only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            fclk <= 1'b1;
            cnt  <= LOAD;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] != fclk) begin
                if (cnt == '0) begin
                    fclk <= clk_sync[1];
                    cnt  <= LOAD;
                    fall <= fclk;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end else begin
                cnt <= LOAD;
            end
        end
    end

    assign data = data_sync[1];

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard frame receiver producing folded make/break key events.
// Build option: PS2_EXT_FILTER_EN suppresses events that carried an E0 prefix.
//
// state  | meaning
// IDLE   | waiting for a start bit (sampled 0 on a falling edge)
// DATA   | shifting 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit, then processing the byte
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_keycode_rx_if.master  ev
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ps2_state_t    state_q, state_d;
    logic          fall, data_bit;
    logic [7:0]    byte_q;
    logic [2:0]    bit_cnt;
    logic          par_q;
    logic [TW-1:0] tmo_cnt;
    logic          brk, ext;
    logic [15:0]   keycode_q;
    logic          start_q, ferr_q;

    logic tmo_hit, frame_start, shift_en, par_en, byte_done, good, err, emit;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data     (data_bit)
    );

    // A falling edge in the expiry cycle takes priority over the timeout.
    assign tmo_hit = (state_q != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (fall && !data_bit)         state_d = DATA;
            DATA:   if (fall && bit_cnt == 3'd7)   state_d = PARITY;
            PARITY: if (fall)                      state_d = STOP;
            STOP:   if (fall)                      state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
    end

    // Per-state datapath strobes and frame verdict.
    always_comb begin
        frame_start = (state_q == IDLE) && fall && !data_bit;
        shift_en    = (state_q == DATA) && fall;
        par_en      = (state_q == PARITY) && fall;
        byte_done   = (state_q == STOP) && fall;
        good        = byte_done && data_bit && (^{byte_q, par_q});
        err         = (byte_done && !(data_bit && (^{byte_q, par_q}))) || tmo_hit;
`ifdef PS2_EXT_FILTER_EN
        emit        = !ext;
`else
        emit        = 1'b1;
`endif
    end

    // Shift register, counters, prefix flags and registered event outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_q    <= 8'h00;
            bit_cnt   <= 3'd0;
            par_q     <= 1'b0;
            tmo_cnt   <= '0;
            brk       <= 1'b0;
            ext       <= 1'b0;
            keycode_q <= 16'h0000;
            start_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            ferr_q  <= 1'b0;

            if (state_q == IDLE || fall || tmo_hit) tmo_cnt <= '0;
            else                                    tmo_cnt <= tmo_cnt + 1'b1;

            if (frame_start) bit_cnt <= 3'd0;
            if (shift_en) begin
                byte_q  <= {data_bit, byte_q[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (par_en) par_q <= data_bit;

            if (err) begin
                ferr_q <= 1'b1;
                brk    <= 1'b0;
                ext    <= 1'b0;
            end else if (good) begin
                if (byte_q == PS2_BREAK) begin
                    brk <= 1'b1;
                end else if (byte_q == PS2_EXT) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (emit) begin
                        keycode_q <= {brk ? PS2_BREAK : 8'h00, byte_q};
                        start_q   <= 1'b1;
                    end
                end
            end
        end
    end

    assign ev.keycode   = keycode_q;
    assign ev.start     = start_q;
    assign ev.frame_err = ferr_q;

endmodule
